// File: rtl/span_renderer_if.sv
// Configuration bus for span_renderer: shadow-table writes, commit request and
// the pending flag returned by the renderer.
interface span_renderer_if #(
  parameter int NUM_LAYERS = 2,
  parameter int ROWS       = 8,
  parameter int SPANS      = 2,
  parameter int COORD_W    = 10
);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = $clog2(2*SPANS+1);

  logic               cfg_we;
  logic [LW-1:0]      cfg_layer;
  logic [RW-1:0]      cfg_row;
  logic [SW-1:0]      cfg_slot;
  logic [COORD_W+7:0] cfg_data;
  logic               cfg_commit;
  logic               commit_pending;

  modport master (output cfg_we, cfg_layer, cfg_row, cfg_slot, cfg_data, cfg_commit,
                  input  commit_pending);
  modport slave  (input  cfg_we, cfg_layer, cfg_row, cfg_slot, cfg_data, cfg_commit,
                  output commit_pending);
endinterface

// File: rtl/span_renderer.sv
// Layered span renderer: per-layer band/edge walkers over an animated edge table,
// with a shadow table committed at frame start and a multi-mode frame counter.
// dir | meaning:  DIR_UP = ping-pong counting up,  DIR_DOWN = ping-pong counting down
module span_renderer #(
  parameter int NUM_LAYERS = 2,
  parameter int ROWS       = 8,
  parameter int SPANS      = 2,
  parameter int COORD_W    = 10,
  parameter int FRAME_W    = 9,
  parameter int COLOUR_W   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           next_frame,
  input  logic                           line_phase,
  input  logic [COORD_W-1:0]             x_pos,
  input  logic [COORD_W-1:0]             y_pos,
  input  logic                           frame_run,
  input  logic                           frame_clear,
  input  logic [1:0]                     frame_mode,
  span_renderer_if.slave                 cfg,
  input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour,
  input  logic [COLOUR_W-1:0]            bg_colour,
  output logic [COLOUR_W-1:0]            colour,
  output logic [NUM_LAYERS-1:0]          layer_hit,
  output logic [FRAME_W-1:0]             frame
);
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SLOTS = 2*SPANS + 1;
  localparam int SW    = $clog2(SLOTS);
  localparam int ENT_W = COORD_W + 8;
  localparam int PW    = COORD_W + 6;

  localparam logic [ENT_W-1:0]   ENT_OFF = {8'h00, {COORD_W{1'b1}}};
  localparam logic [SW-1:0]      E_MAX   = SW'(2*SPANS);
  localparam logic [RW-1:0]      B_MAX   = RW'(ROWS-1);
  localparam logic [FRAME_W-1:0] F_MAX   = '1;

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  dir_t dir;

  logic [ENT_W-1:0] shd_tbl [NUM_LAYERS][ROWS][SLOTS];
  logic [ENT_W-1:0] act_tbl [NUM_LAYERS][ROWS][SLOTS];
  logic [RW-1:0]    band [NUM_LAYERS];
  logic [SW-1:0]    eidx [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] in_span, y_hit, x_hit;
  logic [COLOUR_W-1:0]   colour_nxt;
  logic pending, wr_ok;

  // Only the low COORD_W+1 bits of the shifted product matter (modular edge).
  function automatic logic edge_hit(input logic [ENT_W-1:0] ent,
                                    input logic [FRAME_W-1:0] fr,
                                    input logic [COORD_W-1:0] pos);
    logic signed [7:0]    vel;
    logic signed [PW-1:0] vel_x, fr_x, prod;
    logic [COORD_W:0]     off, edge_pos;
    vel      = ent[ENT_W-1 -: 8];
    vel_x    = PW'(vel);
    fr_x     = PW'({1'b0, fr});
    prod     = vel_x * fr_x;
    off      = (COORD_W+1)'(prod >>> 5);
    edge_pos = {1'b0, ent[COORD_W-1:0]} + off;
    return (ent[COORD_W-1:0] != {COORD_W{1'b1}}) && (edge_pos == {1'b0, pos});
  endfunction

  assign wr_ok = cfg.cfg_we && (cfg.cfg_slot < SW'(SLOTS));
  assign cfg.commit_pending = pending;

  always_comb begin
    y_hit = '0;
    x_hit = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      y_hit[l] = edge_hit(act_tbl[l][band[l]][0], frame, y_pos);
      if (eidx[l] != E_MAX)
        x_hit[l] = edge_hit(act_tbl[l][band[l]][eidx[l] + SW'(1)], frame, x_pos);
    end
  end

  always_comb begin
    colour_nxt = bg_colour;
    for (int l = NUM_LAYERS-1; l >= 0; l--)
      if (in_span[l]) colour_nxt = layer_colour[l*COLOUR_W +: COLOUR_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
      dir   <= DIR_UP;
    end else if (frame_clear) begin
      frame <= '0;
      dir   <= DIR_UP;
    end else if (next_frame && frame_run) begin
      case (frame_mode)
        2'd0: frame <= frame + FRAME_W'(1);
        2'd1: if (frame != F_MAX) frame <= frame + FRAME_W'(1);
        2'd2: begin
          if (dir == DIR_UP) begin
            if (frame == F_MAX) begin
              frame <= F_MAX - FRAME_W'(1);
              dir   <= DIR_DOWN;
            end else frame <= frame + FRAME_W'(1);
          end else begin
            if (frame == '0) begin
              frame <= FRAME_W'(1);
              dir   <= DIR_UP;
            end else frame <= frame - FRAME_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // A write landing on the commit edge goes to both tables so the copy includes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int l = 0; l < NUM_LAYERS; l++)
        for (int r = 0; r < ROWS; r++)
          for (int s = 0; s < SLOTS; s++) begin
            shd_tbl[l][r][s] <= ENT_OFF;
            act_tbl[l][r][s] <= ENT_OFF;
          end
    end else begin
      if (wr_ok) shd_tbl[cfg.cfg_layer][cfg.cfg_row][cfg.cfg_slot] <= cfg.cfg_data;
      if (next_frame && pending) begin
        for (int l = 0; l < NUM_LAYERS; l++)
          for (int r = 0; r < ROWS; r++)
            for (int s = 0; s < SLOTS; s++)
              act_tbl[l][r][s] <= shd_tbl[l][r][s];
        if (wr_ok) act_tbl[cfg.cfg_layer][cfg.cfg_row][cfg.cfg_slot] <= cfg.cfg_data;
        pending <= 1'b0;
      end else if (cfg.cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_span   <= '0;
      colour    <= '0;
      layer_hit <= '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        band[l] <= '0;
        eidx[l] <= '0;
      end
    end else begin
      colour    <= colour_nxt;
      layer_hit <= in_span;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (next_frame) begin
          band[l]    <= '0;
          eidx[l]    <= '0;
          in_span[l] <= 1'b0;
        end else if (line_phase) begin
          eidx[l]    <= '0;
          in_span[l] <= 1'b0;
          if (y_hit[l] && band[l] != B_MAX) band[l] <= band[l] + RW'(1);
        end else if (x_hit[l]) begin
          eidx[l]    <= eidx[l] + SW'(1);
          in_span[l] <= ~in_span[l];
        end
      end
    end
  end
endmodule

// File: tb/tb_span_renderer.sv
// Directed bench for span_renderer: reset, span rendering, animation, layering,
// commit timing, band advance and frame-counter modes.
module tb_span_renderer;
  localparam int NL = 2, ROWS = 8, SPANS = 2, CW = 10, FW = 9, COLW = 6;
  localparam logic [5:0] C0 = 6'h3c, C1 = 6'h15, BG = 6'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, next_frame, line_phase, frame_run, frame_clear;
  logic [CW-1:0] x_pos, y_pos;
  logic [1:0] frame_mode;
  logic [NL*COLW-1:0] layer_colour;
  logic [COLW-1:0] bg_colour, colour;
  logic [NL-1:0] layer_hit;
  logic [FW-1:0] frame;

  int n_cmp = 0;
  int n_err = 0;

  span_renderer_if #(.NUM_LAYERS(NL), .ROWS(ROWS), .SPANS(SPANS), .COORD_W(CW)) cfg_bus ();

  span_renderer #(.NUM_LAYERS(NL), .ROWS(ROWS), .SPANS(SPANS), .COORD_W(CW),
                  .FRAME_W(FW), .COLOUR_W(COLW)) dut (
    .clk(clk), .rst(rst), .next_frame(next_frame), .line_phase(line_phase),
    .x_pos(x_pos), .y_pos(y_pos), .frame_run(frame_run), .frame_clear(frame_clear),
    .frame_mode(frame_mode), .cfg(cfg_bus), .layer_colour(layer_colour),
    .bg_colour(bg_colour), .colour(colour), .layer_hit(layer_hit), .frame(frame)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input int layer, input int row, input int slot,
                        input logic [9:0] base, input logic [7:0] vel);
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_layer = layer[0];
    cfg_bus.cfg_row   = row[2:0];
    cfg_bus.cfg_slot  = slot[2:0];
    cfg_bus.cfg_data  = {vel, base};
    tick();
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_bus.cfg_commit = 1'b1;
    tick();
    cfg_bus.cfg_commit = 1'b0;
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
  endtask

  task automatic nf_pulses(input int n);
    next_frame = 1'b1;
    repeat (n) tick();
    next_frame = 1'b0;
  endtask

  // One line: two blanking cycles at y, then x = lo..hi; spans are [a,b) in x.
  task automatic sweep(input int y, input int lo, input int hi, input int a0, input int b0,
                       input int a1, input int b1, input string tag);
    logic h0, h1;
    logic [5:0] exp_col;
    x_pos = '0;
    y_pos = y[9:0];
    line_phase = 1'b1;
    tick();
    tick();
    line_phase = 1'b0;
    for (int x = lo; x <= hi; x++) begin
      x_pos = x[9:0];
      tick();
      h0 = (x-1 >= a0) && (x-1 < b0);
      h1 = (x-1 >= a1) && (x-1 < b1);
      exp_col = h0 ? C0 : (h1 ? C1 : BG);
      chk({tag, "_col"}, 32'(colour), 32'(exp_col));
      chk({tag, "_hit"}, 32'(layer_hit), 32'({h1, h0}));
    end
  endtask

  initial begin
    rst = 1'b1; next_frame = 1'b0; line_phase = 1'b0; frame_run = 1'b0;
    frame_clear = 1'b0; frame_mode = 2'd0; x_pos = '0; y_pos = '0;
    layer_colour = {C1, C0}; bg_colour = BG;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_layer = '0; cfg_bus.cfg_row = '0;
    cfg_bus.cfg_slot = '0; cfg_bus.cfg_data = '0; cfg_bus.cfg_commit = 1'b0;

    tick(); tick();
    chk("rst_colour", 32'(colour), 32'h0);
    chk("rst_hit", 32'(layer_hit), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
    chk("rst_pending", 32'(cfg_bus.commit_pending), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_bg", 32'(colour), 32'(BG));

    // Static span 100..200 on layer 0
    cfg_wr(0, 0, 1, 10'd100, 8'h00);
    cfg_wr(0, 0, 2, 10'd200, 8'h00);
    chk("wr_no_pending", 32'(cfg_bus.commit_pending), 32'h0);
    cfg_bus.cfg_commit = 1'b1; tick(); cfg_bus.cfg_commit = 1'b0;
    chk("commit_pending_set", 32'(cfg_bus.commit_pending), 32'h1);
    sweep(0, 95, 105, 0, 0, 0, 0, "precommit");
    next_frame = 1'b1; tick(); next_frame = 1'b0;
    chk("commit_pending_clr", 32'(cfg_bus.commit_pending), 32'h0);
    sweep(0, 0, 260, 100, 200, 0, 0, "span100_200");

    // vel +1.0 at frame 7 moves the start edge to 107
    cfg_wr(0, 0, 1, 10'd100, 8'h20);
    cfg_wr(0, 0, 2, 10'd300, 8'h00);
    cfg_bus.cfg_commit = 1'b1; tick(); cfg_bus.cfg_commit = 1'b0;
    frame_clear = 1'b1; tick(); frame_clear = 1'b0;
    frame_run = 1'b1; nf_pulses(7); frame_run = 1'b0;
    chk("frame7", 32'(frame), 32'd7);
    sweep(0, 0, 310, 107, 300, 0, 0, "vel_pos");

    // vel -1.0 at frame 200 wraps negative; base all-ones disabled despite vel
    cfg_wr(0, 0, 1, 10'd100, 8'he0);
    cfg_wr(1, 0, 1, 10'h3ff, 8'he0);
    cfg_wr(1, 0, 2, 10'd830, 8'h00);
    cfg_bus.cfg_commit = 1'b1; tick(); cfg_bus.cfg_commit = 1'b0;
    frame_clear = 1'b1; tick(); frame_clear = 1'b0;
    frame_run = 1'b1; nf_pulses(200); frame_run = 1'b0;
    chk("frame200", 32'(frame), 32'd200);
    sweep(0, 0, 840, 0, 0, 0, 0, "vel_neg_off");

    // Two overlapping layers
    cfg_wr(0, 0, 1, 10'd50, 8'h00);
    cfg_wr(0, 0, 2, 10'd150, 8'h00);
    cfg_wr(1, 0, 1, 10'd100, 8'h00);
    cfg_wr(1, 0, 2, 10'd200, 8'h00);
    commit();
    sweep(0, 0, 260, 50, 150, 100, 200, "overlap");

    // Commit coincident with next_frame waits a full frame
    cfg_wr(0, 0, 2, 10'd120, 8'h00);
    cfg_bus.cfg_commit = 1'b1; next_frame = 1'b1; tick();
    cfg_bus.cfg_commit = 1'b0; next_frame = 1'b0;
    chk("coinc_pending", 32'(cfg_bus.commit_pending), 32'h1);
    sweep(0, 0, 260, 50, 150, 100, 200, "coinc_old");
    chk("coinc_pending_hold", 32'(cfg_bus.commit_pending), 32'h1);
    next_frame = 1'b1; tick(); next_frame = 1'b0;
    chk("coinc_pending_clr", 32'(cfg_bus.commit_pending), 32'h0);
    sweep(0, 0, 260, 50, 120, 100, 200, "coinc_new");

    // Last write wins; write on the commit edge is included
    cfg_wr(0, 0, 1, 10'd70, 8'h00);
    cfg_wr(0, 0, 1, 10'd60, 8'h00);
    sweep(0, 0, 260, 50, 120, 100, 200, "shadow_only");
    cfg_bus.cfg_commit = 1'b1; tick(); cfg_bus.cfg_commit = 1'b0;
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_layer = 1'b1; cfg_bus.cfg_row = 3'd0;
    cfg_bus.cfg_slot = 3'd2; cfg_bus.cfg_data = {8'h00, 10'd180};
    next_frame = 1'b1; tick();
    cfg_bus.cfg_we = 1'b0; next_frame = 1'b0;
    chk("edge_wr_pending_clr", 32'(cfg_bus.commit_pending), 32'h0);
    sweep(0, 0, 260, 60, 120, 100, 180, "edge_wr");

    // Band advance: row0 Y=120, row1 Y=121
    cfg_wr(1, 0, 1, 10'h3ff, 8'h00);
    cfg_wr(0, 0, 0, 10'd120, 8'h00);
    cfg_wr(0, 1, 0, 10'd121, 8'h00);
    cfg_wr(0, 1, 1, 10'd10, 8'h00);
    cfg_wr(0, 1, 2, 10'd20, 8'h00);
    cfg_wr(0, 2, 1, 10'd30, 8'h00);
    cfg_wr(0, 2, 2, 10'd40, 8'h00);
    commit();
    sweep(119, 0, 260, 60, 120, 0, 0, "band_row0");
    sweep(120, 0, 260, 10, 20, 0, 0, "band_row1");
    sweep(121, 0, 260, 30, 40, 0, 0, "band_row2");
    sweep(122, 0, 260, 30, 40, 0, 0, "band_hold");

    // Reset mid-frame drops the pending commit and the table
    cfg_wr(0, 0, 1, 10'd5, 8'h00);
    cfg_bus.cfg_commit = 1'b1; tick(); cfg_bus.cfg_commit = 1'b0;
    chk("pre_rst_pending", 32'(cfg_bus.commit_pending), 32'h1);
    rst = 1'b1; tick();
    chk("mid_rst_pending", 32'(cfg_bus.commit_pending), 32'h0);
    chk("mid_rst_colour", 32'(colour), 32'h0);
    chk("mid_rst_frame", 32'(frame), 32'h0);
    rst = 1'b0; tick();
    chk("mid_rst_bg", 32'(colour), 32'(BG));
    next_frame = 1'b1; tick(); next_frame = 1'b0;
    sweep(0, 0, 260, 0, 0, 0, 0, "after_rst");

    // Frame counter modes
    frame_run = 1'b1; frame_mode = 2'd0;
    nf_pulses(510);
    chk("wrap_510", 32'(frame), 32'd510);
    frame_mode = 2'd2;
    nf_pulses(1); chk("pp_511", 32'(frame), 32'd511);
    nf_pulses(1); chk("pp_510", 32'(frame), 32'd510);
    nf_pulses(1); chk("pp_509", 32'(frame), 32'd509);
    frame_clear = 1'b1; next_frame = 1'b1; tick();
    frame_clear = 1'b0; next_frame = 1'b0;
    chk("clear_over_nf", 32'(frame), 32'd0);
    nf_pulses(1); chk("pp_up_after_clr", 32'(frame), 32'd1);
    frame_mode = 2'd3;
    nf_pulses(1); chk("hold", 32'(frame), 32'd1);
    frame_mode = 2'd0; frame_run = 1'b0;
    nf_pulses(1); chk("run_off", 32'(frame), 32'd1);
    frame_run = 1'b1; frame_mode = 2'd1;
    nf_pulses(515); chk("sat_511", 32'(frame), 32'd511);
    frame_mode = 2'd0;
    nf_pulses(1); chk("wrap_0", 32'(frame), 32'd0);
    frame_run = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
